// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//   DEPTH-stage elastic register chain, WIDTH bits wide, with valid/ready
//   handshakes on both ends. Empty stages (bubbles) collapse, so a stalled
//   output never leaves unused stages between items. Also provides a global
//   enable, a synchronous flush and a registered occupancy count. Used as a
//   retiming / latency-matching element between datapath blocks.
//
// Parameters:
//   WIDTH  data width in bits (>=1)
//   DEPTH  number of register stages (>=1)
//   CNT_W  occupancy count width, 2**CNT_W > DEPTH
//
// Ports:
//   clk        clock, rising edge
//   resetn     synchronous active-low reset (clears valids, data, count)
//   en         global enable; 0 freezes every stage and blocks both handshakes
//   flush      synchronous clear of all stage valids and the count
//   in_valid   upstream data valid
//   in_ready   chain can accept in_data this cycle
//   in_data    upstream data
//   out_valid  last stage holds valid data (gated by en)
//   out_ready  downstream accepts out_data
//   out_data   last stage data
//   count      number of valid stages
//
// Optional feature (macro PIPE_REG_CHAIN_PARITY_EN):
//   Each stage carries an even-parity bit captured at input transfer.
//   par_inject (in)  inverts the captured parity bit during an input transfer
//   par_err    (out) out_valid & (XOR(out_data) != stored parity), combinational
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
`ifdef PIPE_REG_CHAIN_PARITY_EN
  ,
  input  logic             par_inject,
  output logic             par_err
`endif
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] cnt_q;
  logic             load0;
  logic             in_xfer;
  logic             out_xfer;
`ifdef PIPE_REG_CHAIN_PARITY_EN
  logic [DEPTH-1:0] par_p;
`endif

  function automatic logic parity_of(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Stage i may advance when any later stage is empty (a bubble will absorb
  // the shift) or when the output is being drained. This is the unrolled form
  // of adv[i] = !vld[i+1] | adv[i+1], which avoids a self-referencing vector.
  for (genvar g = 0; g < DEPTH; g++) begin : g_adv
    if (g == DEPTH - 1) begin : g_last
      assign adv[g] = out_ready;
    end else begin : g_mid
      assign adv[g] = out_ready | ~(&vld_p[DEPTH-1:g+1]);
    end
  end

  // resetn gating keeps both handshakes idle while the chain is held in reset.
  assign load0     = ~vld_p[0] | adv[0];
  assign in_ready  = resetn & en & ~flush & load0;
  assign out_valid = resetn & en & vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign count     = cnt_q;

`ifdef PIPE_REG_CHAIN_PARITY_EN
  assign par_err = out_valid & (parity_of(out_data) != par_p[DEPTH-1]);
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    if (g == 0) begin : g_in
      // ---- stage 0: capture from upstream ----
      always_ff @(posedge clk) begin
        if (!resetn) begin
          vld_p[0]  <= 1'b0;
          data_p[0] <= '0;
`ifdef PIPE_REG_CHAIN_PARITY_EN
          par_p[0]  <= 1'b0;
`endif
        end else if (flush) begin
          vld_p[0] <= 1'b0;
        end else if (en && load0) begin
          // Loading with in_valid low leaves a bubble; data is kept as is.
          vld_p[0] <= in_valid;
          if (in_valid) begin
            data_p[0] <= in_data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
            par_p[0]  <= parity_of(in_data) ^ par_inject;
`endif
          end
        end
      end
    end else begin : g_shift
      // ---- stage g: shift from stage g-1 ----
      always_ff @(posedge clk) begin
        if (!resetn) begin
          vld_p[g]  <= 1'b0;
          data_p[g] <= '0;
`ifdef PIPE_REG_CHAIN_PARITY_EN
          par_p[g]  <= 1'b0;
`endif
        end else if (flush) begin
          vld_p[g] <= 1'b0;
        end else if (en && (!vld_p[g] || adv[g])) begin
          vld_p[g] <= vld_p[g-1];
          if (vld_p[g-1]) begin
            data_p[g] <= data_p[g-1];
`ifdef PIPE_REG_CHAIN_PARITY_EN
            par_p[g]  <= par_p[g-1];
`endif
          end
        end
      end
    end
  end

  // ---- occupancy count ----
  // A flush drops everything even if downstream took an item in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised successor to the team's single-stage enabled register: a DEPTH-stage elastic pipeline register chain, WIDTH bits wide, with a valid/ready handshake on both ends.
- Empty stages (bubbles) collapse, so a stalled output does not waste stage capacity.
- Adds global enable, synchronous flush and an occupancy count.
- Used as a retiming/latency-matching element between datapath blocks in the synthesis regression designs.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
CNT_W, 3, width of occupancy count; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  reset, synchronous, active-low
en  input  1  global enable; 0 freezes all stages
flush  input  1  synchronous clear of all stage valids
in_valid  input  1  upstream data valid
in_ready  output  1  chain can accept in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  last stage data
count  output  CNT_W  number of valid stages

Behaviour:
- Reset is synchronous and active-low, on clock clk. When resetn==0 at a rising edge:
  - all stage valid bits = 0 and all stage data = 0;
  - count = 0; out_valid = 0; out_data = 0.
- Priority at each edge: resetn > flush > en.
- State per stage i (0..DEPTH-1): valid[i] and data[i]. Stage 0 is the input side; stage DEPTH-1 drives out_data and out_valid.
- Advance terms are combinational, evaluated from output to input:
  - adv[DEPTH-1] = out_ready
  - adv[i] = !valid[i+1] | adv[i+1]
- Output and input ready:
  - out_valid = en & valid[DEPTH-1]. While en==0, out_valid is 0.
  - in_ready = en & !flush & (!valid[0] | adv[0]).
- Stage update at an edge with en==1 and flush==0:
  - Stage i>0 loads from stage i-1 when (!valid[i] | adv[i]). Its new valid = valid[i-1]; data is copied only when valid[i-1]==1, otherwise data is held.
  - Stage 0 loads in_data when in_valid & in_ready. When it can load but in_valid==0, its valid goes to 0.
  - A stage whose valid is 1 and whose adv is 0 holds both data and valid.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Simultaneous input and output transfers are allowed when the chain is full; throughput is 1 per cycle.
- Latency: an item accepted at edge t reaches stage DEPTH-1 at edge t+DEPTH-1, provided there is no downstream stall. out_valid is high in the cycle after that edge.
- count:
  - Registered; equals the number of set valid bits.
  - +1 on input transfer only, -1 on output transfer only, unchanged when both or neither occur.
  - Range 0..DEPTH; never wraps.
- flush==1 (with resetn==1):
  - all valid bits and count cleared at the edge; data not cleared;
  - in_ready = 0 in the flush cycle; any output transfer in that cycle is still counted as completed by downstream.
- en==0: no state change, no handshake completes (in_ready=0, out_valid=0). flush still acts while en==0.
- Full: valid[0..DEPTH-1] all 1 and out_ready==0 -> in_ready=0.
- Empty: count==0 -> out_valid=0.
- DEPTH==1 is legal: the block is a single-entry register with the same handshake.

Optional Feature:
- Macro: PIPE_REG_CHAIN_PARITY_EN.
- When defined:
  - each stage carries an extra parity bit equal to the even parity (XOR) of in_data, captured at input transfer and moved with the data;
  - an added input port par_inject (1 bit) inverts the captured parity bit when high during an input transfer;
  - an added output port par_err (1 bit) = out_valid & (XOR(out_data) != stored parity); it is combinational;
  - reset clears the parity bits.
- When not defined: no parity storage, and neither par_inject nor par_err exists.

Test Plan:
- Reset: hold resetn=0 for 2 edges with in_valid=1 -> out_valid=0, out_data=0, count=0, in_ready=0 while resetn=0; in_ready=1 at the first cycle after release with en=1.
- Latency, DEPTH=4, out_ready=1, en=1: send 0xA5A5A5A5 at edge 0 -> out_valid=1 and out_data=0xA5A5A5A5 after edge 3; count goes 1,1,1,1 and then 0 after the output transfer.
- Back-pressure and bubble collapse:
  - out_ready=0; send 0x1 at edge 0 and 0x2 at edge 2 -> both accepted; send 0x3 and 0x4 -> count=4, in_ready=0.
  - Then set out_ready=1 -> outputs 0x1,0x2,0x3,0x4 on consecutive cycles.
- Full streaming: chain full, in_valid=1 and out_ready=1 for 10 cycles, inputs 0x10..0x19 -> count stays 4, in_ready=1, one output per cycle in order.
- Flush and enable:
  - with count=3, flush=1 for one edge -> count=0, out_valid=0, in_ready=0 during flush;
  - en=0 for 3 cycles with count=2 -> count, data and valids unchanged, out_valid=0.
- Parity (macro defined): send 0x00000001 with par_inject=1 -> par_err=1 when the item reaches the output; send 0x00000003 with par_inject=0 -> par_err=0.
